// File: rtl/ps2_jump_receiver.sv
// Receive-only PS/2 keyboard host: filters ps2_clk, deserialises 11-bit frames,
// tracks E0/F0 prefixes and derives the jump level/pulse from the space-bar code.
module ps2_jump_receiver #(
    parameter int unsigned SYSTEM_FREQ   = 100_000_000,
    parameter int unsigned TIMEOUT_US    = 2000,
    parameter int unsigned FILTER_LEN    = 8,
    parameter logic [7:0]  JUMP_SCANCODE = 8'h29
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_error,
    output logic       jump_held,
    output logic       jump_pulse
);

    localparam int unsigned TO_CYC = (SYSTEM_FREQ / 1_000_000) * TIMEOUT_US;
    localparam int unsigned TO_W   = $clog2(TO_CYC + 1);
    localparam int unsigned FW     = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            filt_q, filt_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            fall_c;
    logic            data_s;

    state_e          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic [7:0]      code_q, code_d;
    logic            valid_q, valid_d, isbrk_q, isbrk_d, isext_q, isext_d;
    logic            ferr_q, ferr_d, held_q, held_d, pulse_q, pulse_d;

    assign data_s = data_sync_q[1];

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // Accept a level change only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall_c = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
                fall_c = filt_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            isbrk_q  <= 1'b0;
            isext_q  <= 1'b0;
            ferr_q   <= 1'b0;
            held_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            tcnt_q   <= tcnt_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            isbrk_q  <= isbrk_d;
            isext_q  <= isext_d;
            ferr_q   <= ferr_d;
            held_q   <= held_d;
            pulse_q  <= pulse_d;
        end
    end

    // Frame FSM, prefix tracking and jump decode.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        tcnt_d   = '0;
        ext_d    = ext_q;
        brk_d    = brk_q;
        code_d   = code_q;
        valid_d  = 1'b0;
        isbrk_d  = isbrk_q;
        isext_d  = isext_q;
        ferr_d   = 1'b0;
        held_d   = held_q;
        pulse_d  = 1'b0;

        if (state_q != S_IDLE && !fall_c && tcnt_q == TO_W'(TO_CYC - 1)) begin
            ferr_d  = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            state_d = S_IDLE;
        end else begin
            if (state_q != S_IDLE && !fall_c) tcnt_d = tcnt_q + TO_W'(1);
            case (state_q)
                S_IDLE: begin
                    if (fall_c && !data_s) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end
                end
                S_DATA: begin
                    if (fall_c) begin
                        shift_d  = {data_s, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (fall_c) begin
                        par_d   = data_s;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (fall_c) begin
                        state_d = S_IDLE;
                        if (!data_s || !(^{shift_q, par_q})) begin
                            ferr_d = 1'b1;
                            ext_d  = 1'b0;
                            brk_d  = 1'b0;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            code_d  = shift_q;
                            isbrk_d = brk_q;
                            isext_d = ext_q;
                            ext_d   = 1'b0;
                            brk_d   = 1'b0;
                            // Typematic repeats keep held high without re-pulsing.
                            if (shift_q == JUMP_SCANCODE && !ext_q) begin
                                if (!brk_q) begin
                                    held_d  = 1'b1;
                                    pulse_d = !held_q;
                                end else begin
                                    held_d = 1'b0;
                                end
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign scancode       = code_q;
    assign scancode_valid = valid_q;
    assign is_break       = isbrk_q;
    assign is_extended    = isext_q;
    assign frame_error    = ferr_q;
    assign jump_held      = held_q;
    assign jump_pulse     = pulse_q;

endmodule

// File: tb/tb_ps2_jump_receiver.sv
// Bench for ps2_jump_receiver: directed and random PS/2 frames compared with a
// behavioural keyboard-host model (event counts, last code, jump state).
module tb_ps2_jump_receiver;

    localparam int unsigned HALF = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       drv_clk, drv_data;
    wire        ps2_clk_w, ps2_data_w;
    logic [7:0] scancode;
    logic       scancode_valid, is_break, is_extended, frame_error, jump_held, jump_pulse;

    assign ps2_clk_w  = drv_clk;
    assign ps2_data_w = drv_data;

    ps2_jump_receiver #(
        .SYSTEM_FREQ  (1_000_000),
        .TIMEOUT_US   (2000),
        .FILTER_LEN   (12),
        .JUMP_SCANCODE(8'h29)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk_w),
        .ps2_data      (ps2_data_w),
        .scancode      (scancode),
        .scancode_valid(scancode_valid),
        .is_break      (is_break),
        .is_extended   (is_extended),
        .frame_error   (frame_error),
        .jump_held     (jump_held),
        .jump_pulse    (jump_pulse)
    );

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_err = 0, n_pulse = 0;

    int         e_valid = 0, e_err = 0, e_pulse = 0;
    logic [7:0] e_code = 8'h00;
    bit         e_brk = 0, e_ext = 0, e_held = 0, m_ext = 0, m_brk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count strobe cycles; every pulse must coincide with a valid strobe.
    always @(negedge clk) begin
        if (reset) begin
            if (scancode_valid) n_valid++;
            if (frame_error) n_err++;
            if (jump_pulse) begin
                n_pulse++;
                chk("pulse_with_valid", 32'(scancode_valid), 32'd1);
            end
        end
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bp, input bit bs);
        return {~bs, (~^b) ^ bp, b, 1'b0};
    endfunction

    // Keyboard-host reference: one received byte at a time.
    task automatic model_byte(input logic [7:0] b, input bit broken);
        if (broken) begin
            e_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            e_valid++;
            e_code = b;
            e_brk  = m_brk;
            e_ext  = m_ext;
            if (b == 8'h29 && !m_ext) begin
                if (!m_brk && !e_held) e_pulse++;
                e_held = !m_brk;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            drv_data = f[i];
            repeat (HALF) @(posedge clk);
            drv_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            drv_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bp, input bit bs);
        send_bits(make_frame(b, bp, bs), 11);
        drv_data = 1'b1;
        repeat (60) @(posedge clk);
        model_byte(b, bp | bs);
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        chk({tag, "/n_valid"}, 32'(n_valid), 32'(e_valid));
        chk({tag, "/n_err"}, 32'(n_err), 32'(e_err));
        chk({tag, "/n_pulse"}, 32'(n_pulse), 32'(e_pulse));
        chk({tag, "/held"}, 32'(jump_held), 32'(e_held));
        chk({tag, "/code"}, 32'(scancode), 32'(e_code));
        chk({tag, "/brk"}, 32'(is_break), 32'(e_brk));
        chk({tag, "/ext"}, 32'(is_extended), 32'(e_ext));
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "/code"}, 32'(scancode), 32'd0);
        chk({tag, "/valid"}, 32'(scancode_valid), 32'd0);
        chk({tag, "/brk"}, 32'(is_break), 32'd0);
        chk({tag, "/ext"}, 32'(is_extended), 32'd0);
        chk({tag, "/ferr"}, 32'(frame_error), 32'd0);
        chk({tag, "/held"}, 32'(jump_held), 32'd0);
        chk({tag, "/pulse"}, 32'(jump_pulse), 32'd0);
    endtask

    task automatic model_reset();
        e_code = 8'h00;
        e_brk  = 0;
        e_ext  = 0;
        e_held = 0;
        m_ext  = 0;
        m_brk  = 0;
    endtask

    initial begin
        logic [7:0] rb;
        int         sel;
        reset    = 1'b0;
        drv_clk  = 1'b1;
        drv_data = 1'b1;
        repeat (5) @(posedge clk);
        check_reset_outputs("reset");
        @(negedge clk) reset = 1'b1;
        repeat (20) @(posedge clk);

        send_byte(8'h29, 0, 0);  check_all("make29");
        send_byte(8'h29, 0, 0);  check_all("repeat29");
        send_byte(8'hF0, 0, 0);
        send_byte(8'h29, 0, 0);  check_all("break29");
        send_byte(8'h29, 0, 0);  check_all("make29_again");
        send_byte(8'h29, 1, 0);  check_all("bad_parity");
        send_byte(8'h1C, 0, 0);  check_all("after_parity_1C");
        send_byte(8'h29, 0, 1);  check_all("bad_stop");
        send_byte(8'hF0, 0, 0);
        send_byte(8'h29, 0, 0);  check_all("break_before_timeout");

        // Partial frame then silence beyond the inter-edge timeout.
        send_bits(make_frame(8'h29, 0, 0), 5);
        drv_data = 1'b1;
        repeat (2500) @(posedge clk);
        model_byte(8'h00, 1);
        check_all("timeout");
        send_byte(8'h29, 0, 0);  check_all("after_timeout_29");

        send_byte(8'hE0, 0, 0);
        send_byte(8'h29, 0, 0);  check_all("ext29");
        send_byte(8'hE0, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h29, 0, 0);  check_all("ext_break29");

        // Reset in the middle of a frame.
        send_bits(make_frame(8'h1C, 0, 0), 4);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        check_reset_outputs("mid_reset");
        model_reset();
        @(negedge clk) reset = 1'b1;
        repeat (20) @(posedge clk);
        send_byte(8'h29, 0, 0);  check_all("after_reset_29");

        // Short ps2_clk glitches, with data both high and low.
        for (int k = 0; k < 6; k++) begin
            drv_data = k[0];
            drv_clk  = 1'b0;
            repeat (10) @(posedge clk);
            drv_clk  = 1'b1;
            repeat (30) @(posedge clk);
        end
        drv_data = 1'b1;
        check_all("glitch");
        send_byte(8'h1C, 0, 0);  check_all("after_glitch_1C");

        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 9));
            rb  = 8'($urandom);
            if (sel == 0) rb = 8'hE0;
            else if (sel <= 2) rb = 8'hF0;
            else if (sel <= 5) rb = 8'h29;
            send_byte(rb, ($urandom_range(0, 9) == 0), 1'b0);
            check_all($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
